csp_rendezvous_channel: RTL and testbench
=========================================

Name: csp_rendezvous_channel

Overview:
- Clocked RTL model of a CSP point-to-point channel with a bundled-data handshake.
- One sender and one receiver perform a rendezvous. A WIDTH-bit token passes only when both sides request, and each side sees a four-phase (or optional two-phase) req/ack handshake.
- Sits between NoC blocks such as arbiters, buffers and routers.
- Exposes a status probe so a receiver can test "sender pending" without consuming the token, which arbitration logic needs.

Parameters:
- WIDTH, 11, token data width in bits.
- HS_PROTOCOL, 0, handshake: 0 = four-phase return-to-zero, 1 = two-phase transition signalling.
- CNT_WIDTH, 16, width of the transferred-token counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_req  in  1  sender request; s_data must be stable while the request is active.
- s_data  in  WIDTH  sender token.
- s_ack  out  1  sender acknowledge.
- r_req  in  1  receiver request (receiver ready to take a token).
- r_ack  out  1  receiver acknowledge; r_data is valid while r_ack is active.
- r_data  out  WIDTH  delivered token (registered).
- status  out  2  0 = IDLE, 1 = S_PEND (sender waiting), 2 = R_PEND (receiver waiting), 3 = BUSY (transfer/release in progress).
- tok_cnt  out  CNT_WIDTH  number of completed transfers, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - s_ack = 0, r_ack = 0, r_data = 0, tok_cnt = 0, status = IDLE.
  - Two-phase phase trackers cleared.
  - A req still held high after reset deasserts is treated as a fresh request.
- "Active request" is defined per protocol:
  - Four-phase: req == 1 with the matching ack == 0.
  - Two-phase: req != the internal last-seen phase bit for that side.
- FSM states:
  - IDLE: no active request. To S_PEND if only the sender is active; to R_PEND if only the receiver is active; to XFER if both are active in the same cycle.
  - S_PEND: to XFER when the receiver becomes active. The sender must not withdraw; withdrawal before ack is illegal and is ignored (no transfer, return to IDLE).
  - R_PEND: to XFER when the sender becomes active. Same withdrawal rule applies to the receiver.
  - XFER: lasts one cycle.
    - Captures r_data <= s_data.
    - Asserts s_ack and r_ack together on the next edge (four-phase: set to 1; two-phase: toggle).
    - Increments tok_cnt.
    - Four-phase goes to REL; two-phase goes to IDLE and updates both phase trackers.
  - REL (four-phase only): each ack drops independently, one cycle after its own req falls. Return to IDLE when both acks are 0. A new request on a side already released waits until IDLE.
- Latency: both requests active at edge N gives acks active after edge N+1. Minimum four-phase cycle per token is 4 clocks when both sides release promptly.
- status: IDLE→0, S_PEND→1, R_PEND→2, XFER/REL→3. It is combinational from state, so a consumer may probe status != IDLE before it requests.
- r_data holds the last token until the next XFER; it is not cleared on release.
- Simultaneous requests arriving in the same cycle go straight to XFER; there is no ordering preference.
- tok_cnt wraps from all-ones to 0 without a flag.

Test Plan:
- Reset: assert rst mid-REL with s_ack = 1 → s_ack, r_ack, tok_cnt and status all 0 immediately, without waiting for clk.
- Sender first: s_req = 1, s_data = 11'h5A3 → status = 1. Then r_req = 1 → both acks = 1 two edges later, r_data = 11'h5A3, tok_cnt = 1. Drop both reqs → acks drop next edge, status = 0.
- Receiver first: r_req = 1 → status = 2. Then s_req = 1, s_data = 11'h002 → r_data = 11'h002, tok_cnt increments; s_ack stays 1 until s_req falls, while r_ack releases independently.
- Stream of 100 random tokens with random per-side release delays of 0–5 cycles → every token received in order, no loss or duplication, tok_cnt = 100.
- HS_PROTOCOL = 1: sender toggles s_req with 11'h7FF while receiver toggles r_req → both acks toggle once, r_data = 11'h7FF. A second toggle pair transfers the next token with no return-to-zero.
- Wrap: CNT_WIDTH = 4 with 17 transfers → tok_cnt = 1.

Source files
------------

// File: rtl/csp_rendezvous_channel_if.sv
// csp_rendezvous_channel_if: bundled-data rendezvous handshake between one sender and one receiver
// Ports (signals): s_req/s_data/s_ack on the sender side, r_req/r_ack/r_data on the receiver side.
// slave is the channel itself; master is the environment that issues requests.
interface csp_rendezvous_channel_if #(
    parameter int WIDTH = 11
);
    logic             s_req;
    logic [WIDTH-1:0] s_data;
    logic             s_ack;
    logic             r_req;
    logic             r_ack;
    logic [WIDTH-1:0] r_data;
    modport slave (
        input  s_req, s_data, r_req,
        output s_ack, r_ack, r_data
    );
    modport master (
        output s_req, s_data, r_req,
        input  s_ack, r_ack, r_data
    );
endinterface

// File: rtl/csp_rendezvous_channel.sv
// csp_rendezvous_channel: CSP point-to-point rendezvous channel, four-phase or two-phase handshake
// Ports: clk, rst (async, active-high), ch (handshake bundle, slave side),
//        status (0 IDLE, 1 sender pending, 2 receiver pending, 3 busy), tok_cnt (completed transfers, wraps).
// The interface WIDTH must match this module's WIDTH.
module csp_rendezvous_channel #(
    parameter int WIDTH       = 11,
    parameter int HS_PROTOCOL = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    csp_rendezvous_channel_if.slave    ch,
    output logic [1:0]                 status,
    output logic [CNT_WIDTH-1:0]       tok_cnt
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] S_PEND = 3'd1;
    localparam logic [2:0] R_PEND = 3'd2;
    localparam logic [2:0] XFER   = 3'd3;
    localparam logic [2:0] REL    = 3'd4;
    localparam bit TWO = (HS_PROTOCOL != 0);

    logic [2:0] state;
    logic       s_ph, r_ph;
    logic       s_act, r_act;

    // Two-phase: a request is a transition away from the last phase seen for that side.
    assign s_act = TWO ? (ch.s_req ^ s_ph) : (ch.s_req & ~ch.s_ack);
    assign r_act = TWO ? (ch.r_req ^ r_ph) : (ch.r_req & ~ch.r_ack);

    always_comb
        status = state == IDLE   ? 2'd0 :
                 state == S_PEND ? 2'd1 :
                 state == R_PEND ? 2'd2 : 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ch.s_ack  <= 1'b0;
            ch.r_ack  <= 1'b0;
            ch.r_data <= '0;
            tok_cnt   <= '0;
            s_ph      <= 1'b0;
            r_ph      <= 1'b0;
        end else begin
            case (state)
                IDLE:   state <= (s_act && r_act) ? XFER : s_act ? S_PEND : r_act ? R_PEND : IDLE;
                // A pending side that withdraws before being acknowledged is dropped without a transfer.
                S_PEND: state <= !s_act ? IDLE : r_act ? XFER : S_PEND;
                R_PEND: state <= !r_act ? IDLE : s_act ? XFER : R_PEND;
                XFER: begin
                    ch.r_data <= ch.s_data;
                    ch.s_ack  <= TWO ? ~ch.s_ack : 1'b1;
                    ch.r_ack  <= TWO ? ~ch.r_ack : 1'b1;
                    s_ph      <= ~s_ph;
                    r_ph      <= ~r_ph;
                    tok_cnt   <= tok_cnt + 1'b1;
                    state     <= TWO ? IDLE : REL;
                end
                // Each ack follows its own req down; leave only once both are already low,
                // so a side released early cannot start a new token before the other finishes.
                REL: begin
                    ch.s_ack <= ch.s_ack & ch.s_req;
                    ch.r_ack <= ch.r_ack & ch.r_req;
                    if (!ch.s_ack && !ch.r_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csp_rendezvous_channel.sv
// tb_csp_rendezvous_channel: directed self-checking bench for four-phase, two-phase and counter-wrap variants
module tb_csp_rendezvous_channel;
    logic clk = 1'b0;
    logic rst;
    logic [1:0]  sa, sb, sc;
    logic [15:0] ca, cb;
    logic [3:0]  cc;
    int n_chk = 0;
    int n_err = 0;
    int cyc, ds, dr;
    logic [10:0] tok;

    always #5 clk = ~clk;

    csp_rendezvous_channel_if #(.WIDTH(11)) ia ();
    csp_rendezvous_channel_if #(.WIDTH(11)) ib ();
    csp_rendezvous_channel_if #(.WIDTH(11)) ic ();

    csp_rendezvous_channel #(.WIDTH(11), .HS_PROTOCOL(0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .ch(ia), .status(sa), .tok_cnt(ca));
    csp_rendezvous_channel #(.WIDTH(11), .HS_PROTOCOL(1), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .ch(ib), .status(sb), .tok_cnt(cb));
    csp_rendezvous_channel #(.WIDTH(11), .HS_PROTOCOL(0), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst(rst), .ch(ic), .status(sc), .tok_cnt(cc));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        ia.s_req = 0; ia.r_req = 0; ia.s_data = '0;
        ib.s_req = 0; ib.r_req = 0; ib.s_data = '0;
        ic.s_req = 0; ic.r_req = 0; ic.s_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_s_ack", ia.s_ack, 0);
        chk("rst_r_ack", ia.r_ack, 0);
        chk("rst_r_data", ia.r_data, 0);
        chk("rst_tok_cnt", ca, 0);
        chk("rst_status", sa, 0);

        // sender first
        ia.s_req = 1; ia.s_data = 11'h5A3;
        @(negedge clk); chk("sf_status_spend", sa, 1);
        ia.r_req = 1;
        @(negedge clk); chk("sf_status_xfer", sa, 3); chk("sf_s_ack_early", ia.s_ack, 0);
        @(negedge clk);
        chk("sf_s_ack", ia.s_ack, 1); chk("sf_r_ack", ia.r_ack, 1);
        chk("sf_r_data", ia.r_data, 11'h5A3); chk("sf_tok_cnt", ca, 1);
        ia.s_req = 0; ia.r_req = 0;
        @(negedge clk); chk("sf_s_ack_rel", ia.s_ack, 0); chk("sf_r_ack_rel", ia.r_ack, 0);
        @(negedge clk); chk("sf_status_idle", sa, 0);

        // withdrawal while pending is dropped
        ia.s_req = 1; ia.s_data = 11'h3FF;
        @(negedge clk); chk("wd_status_spend", sa, 1);
        ia.s_req = 0;
        @(negedge clk); chk("wd_status_idle", sa, 0); chk("wd_tok_cnt", ca, 1);
        chk("wd_r_data_held", ia.r_data, 11'h5A3);

        // receiver first, independent release
        ia.r_req = 1;
        @(negedge clk); chk("rf_status_rpend", sa, 2);
        ia.s_req = 1; ia.s_data = 11'h002;
        repeat (2) @(negedge clk);
        chk("rf_r_data", ia.r_data, 11'h002); chk("rf_tok_cnt", ca, 2);
        chk("rf_s_ack", ia.s_ack, 1); chk("rf_r_ack", ia.r_ack, 1);
        ia.r_req = 0;
        @(negedge clk); chk("rf_r_ack_rel", ia.r_ack, 0); chk("rf_s_ack_hold", ia.s_ack, 1);
        @(negedge clk); chk("rf_s_ack_hold2", ia.s_ack, 1); chk("rf_status_rel", sa, 3);
        ia.s_req = 0;
        @(negedge clk); chk("rf_s_ack_rel", ia.s_ack, 0);
        @(negedge clk); chk("rf_status_idle", sa, 0);

        // async reset in the middle of release with s_ack high
        ia.s_req = 1; ia.r_req = 1; ia.s_data = 11'h123;
        repeat (2) @(negedge clk);
        ia.r_req = 0;
        @(negedge clk); chk("ar_pre_s_ack", ia.s_ack, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_s_ack", ia.s_ack, 0); chk("ar_r_ack", ia.r_ack, 0);
        chk("ar_tok_cnt", ca, 0); chk("ar_status", sa, 0); chk("ar_r_data", ia.r_data, 0);
        @(negedge clk);
        ia.s_req = 0;
        rst = 1'b0;
        @(negedge clk);

        // random token stream with random release delays
        for (int i = 0; i < 100; i++) begin
            tok = 11'($urandom_range(0, 2047));
            ia.s_data = tok; ia.s_req = 1; ia.r_req = 1;
            cyc = 0;
            while (!(ia.s_ack && ia.r_ack) && cyc < 20) begin
                @(negedge clk); cyc++;
            end
            chk("stream_ack", {31'b0, ia.s_ack & ia.r_ack}, 1);
            chk("stream_data", ia.r_data, tok);
            ds = int'($urandom_range(0, 5));
            dr = int'($urandom_range(0, 5));
            cyc = 0;
            while ((ia.s_req || ia.r_req || ia.s_ack || ia.r_ack || sa != 2'd0) && cyc < 40) begin
                if (ds == 0) ia.s_req = 0; else ds--;
                if (dr == 0) ia.r_req = 0; else dr--;
                @(negedge clk); cyc++;
            end
            chk("stream_idle", sa, 0);
        end
        chk("stream_tok_cnt", ca, 100);

        // two-phase transition signalling
        ib.s_req = 1; ib.r_req = 1; ib.s_data = 11'h7FF;
        @(negedge clk); chk("tp_status_xfer", sb, 3);
        @(negedge clk);
        chk("tp_s_ack1", ib.s_ack, 1); chk("tp_r_ack1", ib.r_ack, 1);
        chk("tp_r_data1", ib.r_data, 11'h7FF); chk("tp_status_idle", sb, 0);
        @(negedge clk);
        chk("tp_s_ack_stable", ib.s_ack, 1); chk("tp_tok_cnt1", cb, 1);
        ib.s_req = 0; ib.r_req = 0; ib.s_data = 11'h155;
        repeat (2) @(negedge clk);
        chk("tp_s_ack2", ib.s_ack, 0); chk("tp_r_ack2", ib.r_ack, 0);
        chk("tp_r_data2", ib.r_data, 11'h155); chk("tp_tok_cnt2", cb, 2);

        // 4-bit counter wraps after 16 transfers
        for (int i = 0; i < 17; i++) begin
            ic.s_req = 1; ic.r_req = 1; ic.s_data = 11'(i);
            repeat (2) @(negedge clk);
            ic.s_req = 0; ic.r_req = 0;
            repeat (2) @(negedge clk);
            if (i == 15) chk("wrap_zero", cc, 0);
        end
        chk("wrap_tok_cnt", cc, 1);
        chk("wrap_r_data", ic.r_data, 11'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
